// File: rtl/bin2bcd_8bit_if.sv
// rtl/bin2bcd_8bit_if.sv - Start/Busy/Done handshake and data bundle for the binary-to-BCD converter
interface bin2bcd_8bit_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  Start;
    logic [WIDTH-1:0]      Bin;
    logic                  Busy;
    logic                  Done;
    logic [4*DIGITS-1:0]   Bcd;

    modport master (output Start, output Bin, input Busy, input Done, input Bcd);
    modport slave  (input Start, input Bin, output Busy, output Done, output Bcd);
endinterface

// File: rtl/bin2bcd_8bit.sv
// rtl/bin2bcd_8bit.sv - sequential double-dabble binary-to-BCD converter, one input bit per clock
module bin2bcd_8bit #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int CW     = 4
) (
    input  logic           Clk,
    input  logic           Resetn,
    bin2bcd_8bit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WIDTH-1:0]      r_sh_bin;
    logic [4*DIGITS-1:0]   r_bcd_acc;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_shifted;
    logic                  w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The unused encoding falls through to the default and returns to IDLE.
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_next = bus.Start ? S_SHIFT : S_IDLE;
            S_SHIFT: w_next = w_last ? S_DONE : S_SHIFT;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Add-3 correction is per digit and carry-free, applied before the shift.
    always_comb begin
        w_adj = r_bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd_acc[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_adj[4*DIGITS-2:0], r_sh_bin[WIDTH-1]};

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_sh_bin  <= '0;
            r_bcd_acc <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_sh_bin  <= bus.Bin;
                        r_bcd_acc <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_bcd_acc <= w_shifted;
                    r_sh_bin  <= {r_sh_bin[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_bcd <= w_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Busy = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign bus.Done = (r_state == S_DONE);
    assign bus.Bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_8bit.sv
// tb/tb_bin2bcd_8bit.sv - self-checking bench for bin2bcd_8bit against an arithmetic decimal model
module tb_bin2bcd_8bit;
    logic Clk;
    logic Resetn;
    int   n_checks;
    int   n_fail;

    bin2bcd_8bit_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin2bcd_8bit #(.WIDTH(8), .DIGITS(3), .CW(4)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] model_bcd(input int b);
        int h, t, u;
        h = b / 100;
        t = (b / 10) % 10;
        u = b % 10;
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    // Starts one conversion from IDLE; optionally disturbs Start/Bin while busy.
    task automatic convert(input logic [7:0] b, input bit disturb);
        logic [11:0] exp;
        logic [11:0] prev;
        int          n;
        exp  = model_bcd(int'(b));
        @(negedge Clk);
        prev      = bus.Bcd;
        bus.Start = 1'b1;
        bus.Bin   = b;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        bus.Bin   = 8'($urandom);
        check("busy_after_start", 32'(bus.Busy), 32'd1);
        n = 0;
        while (n < 20) begin
            @(posedge Clk);
            n++;
            #1;
            if (disturb) begin
                bus.Start = (n < 6);
                bus.Bin   = 8'($urandom);
            end
            if (bus.Done) break;
            if (n == 4) check("bcd_held_in_shift", 32'(bus.Bcd), 32'(prev));
        end
        check("done_latency", 32'(n), 32'd8);
        check("bcd_value", 32'(bus.Bcd), 32'(exp));
        check("hundreds_le2", 32'(bus.Bcd[11:8] <= 4'd2), 32'd1);
        check("tens_le9", 32'(bus.Bcd[7:4] <= 4'd9), 32'd1);
        check("units_le9", 32'(bus.Bcd[3:0] <= 4'd9), 32'd1);
        check("decode_back", 32'(bus.Bcd[11:8] * 100 + bus.Bcd[7:4] * 10 + bus.Bcd[3:0]),
              32'(b));
        @(posedge Clk);
        #1;
        check("done_one_cycle", 32'(bus.Done), 32'd0);
        check("idle_after_done", 32'(bus.Busy), 32'd0);
        check("bcd_held_idle", 32'(bus.Bcd), 32'(exp));
    endtask

    initial begin
        int          done_at[$];
        int          edge_n;
        logic [7:0]  corners[6];
        n_checks  = 0;
        n_fail    = 0;
        Resetn    = 1'b0;
        bus.Start = 1'b0;
        bus.Bin   = 8'd0;
        #1;
        check("reset_busy", 32'(bus.Busy), 32'd0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_bcd", 32'(bus.Bcd), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Resetn = 1'b1;

        corners = '{8'd0, 8'd255, 8'd225, 8'd144, 8'd9, 8'd100};
        foreach (corners[i]) convert(corners[i], 1'b0);

        // Asynchronous reset between edges clears outputs immediately.
        @(posedge Clk);
        #3;
        Resetn = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.Busy), 32'd0);
        check("async_rst_done", 32'(bus.Done), 32'd0);
        check("async_rst_bcd", 32'(bus.Bcd), 32'd0);
        @(negedge Clk);
        Resetn = 1'b1;

        // Start held high: one conversion every 10 clocks.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Bin   = 8'd42;
        edge_n    = 0;
        while (done_at.size() < 3 && edge_n < 60) begin
            @(posedge Clk);
            edge_n++;
            #1;
            if (bus.Done) begin
                done_at.push_back(edge_n);
                check("held_bcd", 32'(bus.Bcd), 32'h042);
            end
        end
        check("held_done_count", 32'(done_at.size()), 32'd3);
        if (done_at.size() == 3) begin
            check("held_period_a", 32'(done_at[1] - done_at[0]), 32'd10);
            check("held_period_b", 32'(done_at[2] - done_at[1]), 32'd10);
        end
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (12) @(posedge Clk);
        #1;
        check("held_release_idle", 32'(bus.Busy), 32'd0);

        // Reset in the 4th SHIFT cycle discards the conversion of 199.
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Bin   = 8'd199;
        @(posedge Clk);
        #1;
        bus.Start = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        Resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.Busy), 32'd0);
        check("mid_rst_done", 32'(bus.Done), 32'd0);
        check("mid_rst_bcd", 32'(bus.Bcd), 32'd0);
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        repeat (10) begin
            @(posedge Clk);
            #1;
            check("no_done_after_rst", 32'(bus.Done), 32'd0);
        end
        convert(8'd57, 1'b0);

        for (int v = 0; v < 256; v++) convert(8'(v), 1'b0);
        repeat (40) convert(8'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
